// File: rtl/dram_sched_pkg.sv
// Shared command encodings, scheduler state type and address-field helpers.
package dram_sched_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitRp,
    StAct,
    StWaitRcd,
    StAccess
  } state_e;

  // Extract a width-bit field starting at lsb; callers cast down to the field width.
  function automatic logic [31:0] field_slice(logic [31:0] addr, int unsigned lsb,
                                              int unsigned width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any_valid
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (req[idx]) begin
        grant_id  = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_bank_scheduler.sv
// Round-robin DRAM request scheduler with per-bank open-row tracking and
// PRECHARGE/ACTIVATE/READ-WRITE sequencing under tRP/tRCD spacing.
module dram_bank_scheduler
  import dram_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 8,
  parameter int unsigned NUMBER_OF_BANKS = 8,
  parameter int unsigned NUMBER_OF_ROWS  = 128,
  parameter int unsigned NUMBER_OF_COLS  = 8,
  parameter int unsigned L2_REQ_WIDTH    = 13,
  parameter int unsigned T_RP            = 2,
  parameter int unsigned T_RCD           = 2
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*L2_REQ_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]                 req_rw,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [1:0]                         cmd,
  output logic [$clog2(NUMBER_OF_BANKS)-1:0] cmd_bank,
  output logic [$clog2(NUMBER_OF_ROWS)-1:0]  cmd_row,
  output logic [$clog2(NUMBER_OF_COLS)-1:0]  cmd_col,
  output logic                               cmd_rw,
  output logic [$clog2(NUM_REQ)-1:0]         cmd_req_id,
  output logic                               busy
);

  localparam int unsigned BW = $clog2(NUMBER_OF_BANKS);
  localparam int unsigned RW = $clog2(NUMBER_OF_ROWS);
  localparam int unsigned CW = $clog2(NUMBER_OF_COLS);
  localparam int unsigned IW = $clog2(NUM_REQ);

  state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_id;
  logic          any_valid;

  logic [L2_REQ_WIDTH-1:0] sel_addr;
  logic [BW-1:0]           sel_bank;
  logic [RW-1:0]           sel_row;
  logic [CW-1:0]           sel_col;

  logic [IW-1:0] id_q;
  logic [BW-1:0] bank_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          rw_q;

  logic [NUMBER_OF_BANKS-1:0] open_q;
  logic [RW-1:0]              open_row_q [NUMBER_OF_BANKS];

  logic latch_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant_id  (grant_id),
    .any_valid (any_valid)
  );

  assign sel_addr = req_addr[grant_id*L2_REQ_WIDTH +: L2_REQ_WIDTH];
  assign sel_bank = BW'(field_slice(32'(sel_addr), RW + CW, BW));
  assign sel_row  = RW'(field_slice(32'(sel_addr), CW, RW));
  assign sel_col  = CW'(field_slice(32'(sel_addr), 0, CW));
  assign latch_en = (state_q == StIdle) && any_valid;

  // Next-state selection and Moore command outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cmd        = CMD_NOP;
    cmd_bank   = '0;
    cmd_row    = '0;
    cmd_col    = '0;
    cmd_rw     = 1'b0;
    cmd_req_id = '0;
    req_ready  = '0;
    busy       = 1'b1;
    if (state_q != StIdle) begin
      cmd_bank   = bank_q;
      cmd_row    = row_q;
      cmd_col    = col_q;
      cmd_req_id = id_q;
    end
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (any_valid) begin
          if (open_q[sel_bank] && (open_row_q[sel_bank] == sel_row)) begin
            state_d = StAccess;
          end else if (open_q[sel_bank]) begin
            state_d = StPre;
          end else begin
            state_d = StAct;
          end
        end
      end
      StPre: begin
        cmd = CMD_PRE;
        if (T_RP > 1) begin
          state_d = StWaitRp;
          wait_d  = 8'(T_RP - 2);
        end else begin
          state_d = StAct;
        end
      end
      StWaitRp: begin
        if (wait_q == '0) state_d = StAct;
        else              wait_d  = wait_q - 8'd1;
      end
      StAct: begin
        cmd = CMD_ACT;
        if (T_RCD > 1) begin
          state_d = StWaitRcd;
          wait_d  = 8'(T_RCD - 2);
        end else begin
          state_d = StAccess;
        end
      end
      StWaitRcd: begin
        if (wait_q == '0) state_d = StAccess;
        else              wait_d  = wait_q - 8'd1;
      end
      StAccess: begin
        cmd             = CMD_RW;
        cmd_rw          = rw_q;
        req_ready[id_q] = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Capture the winning request once; it is not re-sampled afterwards.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      id_q   <= '0;
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      rw_q   <= 1'b0;
    end else if (latch_en) begin
      id_q   <= grant_id;
      bank_q <= sel_bank;
      row_q  <= sel_row;
      col_q  <= sel_col;
      rw_q   <= req_rw[grant_id];
    end
  end

  // Round-robin pointer moves past the requester just completed.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr_q <= '0;
    end else if (state_q == StAccess) begin
      rr_ptr_q <= (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  // Bank table: PRECHARGE closes the bank, ACTIVATE opens it on the latched row.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      open_q <= '0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) open_row_q[b] <= '0;
    end else if (state_q == StPre) begin
      open_q[bank_q] <= 1'b0;
    end else if (state_q == StAct) begin
      open_q[bank_q]     <= 1'b1;
      open_row_q[bank_q] <= row_q;
    end
  end

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Directed bench for dram_bank_scheduler; expected values are hand-derived.
module tb_dram_bank_scheduler;

  localparam int unsigned NR = 8;
  localparam int unsigned AW = 13;

  logic            clk;
  logic            rst_b;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_rw;
  logic [NR-1:0]   req_ready;
  logic [1:0]      cmd;
  logic [2:0]      cmd_bank;
  logic [6:0]      cmd_row;
  logic [2:0]      cmd_col;
  logic            cmd_rw;
  logic [2:0]      cmd_req_id;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  dram_bank_scheduler dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_rw     (req_rw),
    .req_ready  (req_ready),
    .cmd        (cmd),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_rw     (cmd_rw),
    .cmd_req_id (cmd_req_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w);
    req_valid[i]         = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_rw[i]            = w;
  endtask

  task automatic drop_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // Checks one hit access: IDLE now, READ/WRITE + ready on the next cycle, IDLE after.
  task automatic hit_access(input string tag, input int id, input logic [2:0] col);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_cmd"}, 32'(cmd), 32'd2);
    check({tag, "_id"}, 32'(cmd_req_id), 32'(id));
    check({tag, "_col"}, 32'(cmd_col), 32'(col));
    check({tag, "_ready"}, 32'(req_ready), 32'd1 << id);
    drop_req(id);
    tick();
  endtask

  initial begin
    rst_b     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_rw    = '0;
    #12;
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_fields", {cmd_bank, cmd_row, cmd_col, cmd_rw, cmd_req_id}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // Closed bank: ACT at 1, READ at 3.
    set_req(3, 13'h0405, 1'b0);
    check("t1_c0_cmd", 32'(cmd), 32'd0);
    tick();
    check("t1_c1_cmd", 32'(cmd), 32'd1);
    check("t1_c1_bank", 32'(cmd_bank), 32'd1);
    check("t1_c1_row", 32'(cmd_row), 32'd0);
    check("t1_c1_id", 32'(cmd_req_id), 32'd3);
    check("t1_c1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_c2_cmd", 32'(cmd), 32'd0);
    check("t1_c2_ready", 32'(req_ready), 32'd0);
    tick();
    check("t1_c3_cmd", 32'(cmd), 32'd2);
    check("t1_c3_col", 32'(cmd_col), 32'd5);
    check("t1_c3_rw", 32'(cmd_rw), 32'd0);
    check("t1_c3_ready", 32'(req_ready), 32'h08);
    drop_req(3);
    tick();
    check("t1_c4_busy", 32'(busy), 32'd0);
    check("t1_c4_cmd", 32'(cmd), 32'd0);

    // Same address again: row hit.
    set_req(3, 13'h0405, 1'b0);
    hit_access("t2", 3, 3'd5);

    // Conflict on bank 1 (row 7, col 2) write: PRE 1, ACT 3, WRITE 5.
    set_req(0, 13'h043A, 1'b1);
    tick();
    check("t3_c1_cmd", 32'(cmd), 32'd3);
    check("t3_c1_bank", 32'(cmd_bank), 32'd1);
    tick();
    check("t3_c2_cmd", 32'(cmd), 32'd0);
    tick();
    check("t3_c3_cmd", 32'(cmd), 32'd1);
    check("t3_c3_row", 32'(cmd_row), 32'd7);
    tick();
    check("t3_c4_cmd", 32'(cmd), 32'd0);
    tick();
    check("t3_c5_cmd", 32'(cmd), 32'd2);
    check("t3_c5_rw", 32'(cmd_rw), 32'd1);
    check("t3_c5_col", 32'(cmd_col), 32'd2);
    check("t3_c5_ready", 32'(req_ready), 32'h01);
    drop_req(0);
    tick();

    // Requester 7 hit brings the pointer back to 0.
    set_req(7, 13'h043F, 1'b0);
    hit_access("t4_pre", 7, 3'd7);

    // All eight valid, all hits on bank 1 row 7: served 0..7, one per 2 cycles.
    for (int i = 0; i < NR; i++) set_req(i, 13'h0438 | 13'(i), 1'b0);
    for (int k = 0; k < NR; k++) hit_access($sformatf("t4_all%0d", k), k, 3'(k));

    // Pointer wrapped to 0: 0 beats 4; then 4 leaves pointer at 5.
    set_req(4, 13'h0439, 1'b0);
    set_req(0, 13'h043B, 1'b0);
    hit_access("t5_w0", 0, 3'd3);
    hit_access("t5_w4", 4, 3'd1);

    // Pointer 5 with 2 and 6 valid: 6 first, then 2.
    set_req(2, 13'h043C, 1'b0);
    set_req(6, 13'h043E, 1'b0);
    hit_access("t5_r6", 6, 3'd6);
    hit_access("t5_r2", 2, 3'd4);

    // Reset during WAIT_RCD: bank 2 row 3 col 1 from requester 1.
    set_req(1, 13'h0819, 1'b0);
    tick();
    check("t6_c1_cmd", 32'(cmd), 32'd1);
    check("t6_c1_bank", 32'(cmd_bank), 32'd2);
    tick();
    rst_b = 1'b0;
    #1;
    check("t6_rst_cmd", 32'(cmd), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    drop_req(1);
    tick();
    check("t6_rst_ready2", 32'(req_ready), 32'd0);
    rst_b = 1'b1;
    tick();

    // Bank 1 row 7 was open before reset; table cleared, so ACT not hit.
    set_req(1, 13'h043A, 1'b0);
    tick();
    check("t7_c1_cmd", 32'(cmd), 32'd1);
    check("t7_c1_row", 32'(cmd_row), 32'd7);
    check("t7_c1_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    check("t7_c3_cmd", 32'(cmd), 32'd2);
    check("t7_c3_ready", 32'(req_ready), 32'h02);
    drop_req(1);
    tick();
    check("t7_c4_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_bank_scheduler.md
# dram_bank_scheduler

Front-end scheduler for the DRAM controller. Accepts read/write requests from eight L2 requesters, selects one at a time by round-robin and tracks the open row of every bank. It then sequences PRECHARGE/ACTIVATE/READ-WRITE commands with tRP/tRCD spacing to the bank array and completes each request with a one-cycle ready pulse.

## Interface
- NUM_REQ, 8, number of requesters
- NUMBER_OF_BANKS, 8, banks; BW = $clog2(NUMBER_OF_BANKS)
- NUMBER_OF_ROWS, 128, rows per bank; RW = $clog2(NUMBER_OF_ROWS)
- NUMBER_OF_COLS, 8, columns per row; CW = $clog2(NUMBER_OF_COLS)
- L2_REQ_WIDTH, 13, request address width, must equal BW+RW+CW
- T_RP, 2, cycles from PRECHARGE to ACTIVATE, ≥1
- T_RCD, 2, cycles from ACTIVATE to READ/WRITE, ≥1
- Ports:
- clk  in  1  clock; all state on rising edge
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*L2_REQ_WIDTH  requester i at [i*L2_REQ_WIDTH +: L2_REQ_WIDTH]; bank=MSBs, row=middle, col=LSBs
- req_rw  in  NUM_REQ  1=write, 0=read
- req_ready  out  NUM_REQ  one-hot, one-cycle completion pulse
- cmd  out  2  00 NOP, 01 ACTIVATE, 10 READ/WRITE, 11 PRECHARGE
- cmd_bank  out  BW  target bank
- cmd_row  out  RW  row (meaningful on ACTIVATE)
- cmd_col  out  CW  column (meaningful on READ/WRITE)
- cmd_rw  out  1  1=write on READ/WRITE
- cmd_req_id  out  $clog2(NUM_REQ)  requester owning current command
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, ACCESS.
- IDLE: if any req_valid, the round-robin winner is the first valid index at or after rr_ptr (wrapping). Its id, bank, row, col and rw are latched.
- Next state is chosen from the bank table at latch time:
  - bank open on the same row (hit) -> ACCESS
  - bank closed -> ACT
  - bank open on a different row (conflict) -> PRE
- PRE: cmd=11 for one cycle; clear the bank's open bit; WAIT_RP for T_RP-1 cycles (skipped if T_RP=1); then ACT.
- ACT: cmd=01 with latched row; set the open bit and store the row; WAIT_RCD for T_RCD-1 cycles; then ACCESS.
- ACCESS: cmd=10 with col/rw; req_ready[id]=1 in the same cycle; rr_ptr <= id+1 mod NUM_REQ; next state IDLE.
- Open-page policy: rows stay open after access.
- Requesters hold valid/addr/rw stable until their req_ready. The request is latched once and not re-sampled. Deasserting early is a protocol violation with no defined effect.
- cmd_bank/cmd_req_id reflect the latched request in all non-IDLE states. All cmd_* outputs are 0 in IDLE.

## Timing
- Reset values: cmd=00, req_ready=0, busy=0, all cmd_* =0, rr_ptr=0, all banks closed, state IDLE.
- Cycle 0 is the IDLE cycle in which the request is latched.
  - Hit: READ/WRITE + req_ready at cycle 1.
  - Closed bank: ACT at 1, READ/WRITE at 1+T_RCD.
  - Conflict: PRE at 1, ACT at 1+T_RP, READ/WRITE at 1+T_RP+T_RCD.
- Back-to-back hits: one access every 2 cycles. A request raised in the ACCESS cycle is eligible in the following IDLE cycle.
- Simultaneous valids: exactly one winner per IDLE cycle. The others wait, and each waits at most NUM_REQ-1 grants.
- rst_b low mid-sequence: immediate return to reset values. The bank table is cleared and the in-flight request is dropped without req_ready.

## Structure
- Package dram_sched_pkg holds:
  - cmd encodings CMD_NOP/CMD_ACT/CMD_RW/CMD_PRE
  - the state enum
  - address-field slice helpers (bank/row/col widths derived from parameters)
- Sub-module rr_arbiter, a combinational round-robin pick with inputs req[NUM_REQ] and ptr, and outputs grant_id and any_valid. It is instantiated once; rr_ptr lives in the scheduler.
- Bank table: NUMBER_OF_BANKS open bits + RW-bit row registers.

## Test plan
- After reset, requester 3 reads addr 13'h0405 (bank 1, row 0, col 5) -> ACT bank1 row0 at cycle 1, READ col5 at cycle 3, req_ready[3] at cycle 3.
- Repeat the same address from requester 3 -> hit: READ at cycle 1, no ACT/PRE.
- Requester 0 writes bank 1, row 7 -> PRE at 1, ACT row7 at 3, WRITE at 5 with cmd_rw=1.
- All 8 requesters valid at once, all hits -> req_ready order 0,1,…,7, one every 2 cycles. Next round starts at index 0 after 7.
- rr_ptr=5 with requesters 2 and 6 valid -> 6 served before 2.
- Assert rst_b low during WAIT_RCD -> cmd=00 and no req_ready. The next request to the same bank issues ACT, not a hit.
